instr_fetch_unit: RTL

//  Program-counter owner and instruction-fetch sequencer upstream of the control/decode unit.

---
 rtl/instr_fetch_unit_if.sv | 9 +
 rtl/instr_fetch_unit.sv | 96 +++++++++
 2 files changed

// File: rtl/instr_fetch_unit_if.sv
// instr_fetch_unit_if: instruction-memory fetch bus (req/addr out, ready/rdata back).
interface instr_fetch_unit_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic [31:0] imem_rdata;
  modport master (output imem_req, imem_addr, input imem_ready, imem_rdata);
  modport slave (input imem_req, imem_addr, output imem_ready, imem_rdata);
endinterface

// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: pc owner and fetch/execute sequencer feeding the control unit.
// Define IFU_MISALIGN_CHECK_EN to fault on misaligned redirects instead of aligning them.
module instr_fetch_unit #(
  parameter logic [31:0] RESET_PC       = 32'h0000_0000,
  parameter int          TIMEOUT_CYCLES = 16
) (
  input  logic                      clk,
  input  logic                      rst_n,
  instr_fetch_unit_if.master        imem,
  input  logic                      i_stall,
  input  logic [31:0]               i_branch_target,
  output logic [31:0]               o_instruction,
  output logic [31:0]               o_pc_out,
  output logic                      o_instr_valid,
  output logic [31:0]               o_instr_count,
  output logic                      o_fetch_fault
);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_EXEC, S_FAULT} state_t;
  state_t        r_state, w_state;
  logic [31:0]   r_pc, w_pc, r_pc_out, w_pc_out, r_instr, w_instr, r_count, w_count;
  logic [TW-1:0] r_tmo, w_tmo;
  logic          r_fault, w_fault, w_redir;
  assign w_redir = i_branch_target != 32'd0;
  always_comb begin
    w_state  = r_state;
    w_pc     = r_pc;
    w_pc_out = r_pc_out;
    w_instr  = r_instr;
    w_count  = r_count;
    w_tmo    = r_tmo;
    w_fault  = r_fault;
    case (r_state)
      S_IDLE: w_state = S_FETCH;
      S_FETCH: begin
        if (imem.imem_ready) begin
          w_instr  = imem.imem_rdata;
          w_pc_out = r_pc;
          w_tmo    = '0;
          w_state  = S_EXEC;
        end else begin
          w_tmo = r_tmo + TW'(1);
          if (r_tmo == TW'(TIMEOUT_CYCLES - 1)) begin
            w_fault = 1'b1;
            w_state = S_FAULT;
          end
        end
      end
      S_EXEC: begin
        if (!i_stall) begin
`ifdef IFU_MISALIGN_CHECK_EN
          if (w_redir && i_branch_target[1:0] != 2'b00) begin
            w_fault = 1'b1;
            w_state = S_FAULT;
          end else begin
            w_pc    = w_redir ? i_branch_target : r_pc + 32'd4;
            w_count = r_count + 32'd1;
            w_state = S_FETCH;
          end
`else
          w_pc    = w_redir ? (i_branch_target & ~32'd3) : r_pc + 32'd4;
          w_count = r_count + 32'd1;
          w_state = S_FETCH;
`endif
        end
      end
      default: w_state = S_FAULT;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= S_IDLE;
      r_pc     <= RESET_PC;
      r_pc_out <= RESET_PC;
      r_instr  <= 32'h0000_0013;
      r_count  <= '0;
      r_tmo    <= '0;
      r_fault  <= 1'b0;
    end else begin
      r_state  <= w_state;
      r_pc     <= w_pc;
      r_pc_out <= w_pc_out;
      r_instr  <= w_instr;
      r_count  <= w_count;
      r_tmo    <= w_tmo;
      r_fault  <= w_fault;
    end
  end
  assign imem.imem_req   = r_state == S_FETCH;
  assign imem.imem_addr  = r_pc;
  assign o_instr_valid   = r_state == S_EXEC;
  assign o_instruction   = r_instr;
  assign o_pc_out        = r_pc_out;
  assign o_instr_count   = r_count;
  assign o_fetch_fault   = r_fault;
endmodule
